zigzag_bank_ctrl: RTL and testbench

//  Ping-pong controller for the 2x64-entry coefficient RAM between the DCT and the quantizer.

---
 rtl/zigzag_bank_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_zigzag_bank_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zigzag_bank_ctrl.sv
// zigzag_bank_ctrl: ping-pong controller for a 2 x (DIM*DIM) coefficient RAM.
// The write side fills one bank in raster order. The read side drains the
// other bank in JPEG zigzag order, so filling one bank overlaps with
// scanning the other.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid, in_sop    write-side stream; in_sop marks the first coefficient of a block
//   in_ready            write side can accept (current write bank EMPTY or FILLING)
//   wr_en, wr_addr      RAM write port, address {wbank, raster index}
//   out_hold            downstream pause; no new reads are issued while it is high
//   rd_en, rd_addr      RAM read port, address {rbank, y, x}
//   out_valid/sop/eop   read-data framing, delayed RD_LAT cycles after rd_en
//   out_done            one-cycle pulse together with out_eop
//   err_sop             one-cycle pulse, registered: in_sop was accepted in the middle of a block
module zigzag_bank_ctrl #(
    parameter int unsigned DIM    = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic                     in_sop,
    output logic                     in_ready,
    output logic                     wr_en,
    output logic [2*$clog2(DIM):0]   wr_addr,
    input  logic                     out_hold,
    output logic                     rd_en,
    output logic [2*$clog2(DIM):0]   rd_addr,
    output logic                     out_valid,
    output logic                     out_sop,
    output logic                     out_eop,
    output logic                     out_done,
    output logic                     err_sop
);

    localparam int unsigned LW    = $clog2(DIM);
    localparam int unsigned AW    = 2 * LW;
    localparam int unsigned DEPTH = DIM * DIM;
    localparam logic [LW-1:0] XMAX = LW'(DIM - 1);
    localparam logic [AW-1:0] WLAST = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        B_EMPTY,
        B_FILLING,
        B_FULL,
        B_READING
    } bank_t;

    typedef enum logic {
        R_IDLE,
        R_SCAN
    } rd_state_t;

    bank_t            bstate [2];
    logic             wbank;
    logic             rbank;
    logic [AW-1:0]    wcnt;
    logic [LW-1:0]    x;
    logic [LW-1:0]    y;
    rd_state_t        rstate;
    logic [RD_LAT-1:0] vpipe;
    logic [RD_LAT-1:0] spipe;
    logic [RD_LAT-1:0] epipe;

    logic             sop_err_c;
    logic [AW-1:0]    widx_c;
    logic             wlast_c;
    logic             scan_c;
    logic             rlast_c;
    logic             rsop_c;
    logic             reop_c;
    logic [LW-1:0]    nx;
    logic [LW-1:0]    ny;

    // Write side: an in_sop always lands at index 0; mid-block it restarts the bank.
    assign in_ready  = (bstate[wbank] == B_EMPTY) || (bstate[wbank] == B_FILLING);
    assign wr_en     = in_valid & in_ready;
    assign widx_c    = in_sop ? '0 : wcnt;
    assign wlast_c   = (widx_c == WLAST);
    assign sop_err_c = wr_en & in_sop & (wcnt != '0);
    assign wr_addr   = {wbank, widx_c};

    // Read side: a FULL bank starts the scan in the same cycle it is seen,
    // which gives one cycle from the last write to the first read.
    assign scan_c  = (rstate == R_SCAN) || (bstate[rbank] == B_FULL);
    assign rd_en   = scan_c & ~out_hold;
    assign rlast_c = (x == XMAX) && (y == XMAX);
    assign rsop_c  = rd_en && (x == '0) && (y == '0);
    assign reop_c  = rd_en && rlast_c;
    assign rd_addr = {rbank, y, x};

    assign out_valid = vpipe[RD_LAT-1];
    assign out_sop   = spipe[RD_LAT-1];
    assign out_eop   = epipe[RD_LAT-1];
    assign out_done  = epipe[RD_LAT-1];

    // Zigzag walker step; parity of x+y selects the diagonal direction.
    always_comb begin
        nx = x;
        ny = y;
        if (x[0] == y[0]) begin
            if (x == XMAX) begin
                ny = y + LW'(1);
            end else if (y == '0) begin
                nx = x + LW'(1);
            end else begin
                nx = x + LW'(1);
                ny = y - LW'(1);
            end
        end else begin
            if (y == XMAX) begin
                nx = x + LW'(1);
            end else if (x == '0) begin
                ny = y + LW'(1);
            end else begin
                nx = x - LW'(1);
                ny = y + LW'(1);
            end
        end
    end

    // Bank states, counters, reader FSM and flag delay line.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bstate[0] <= B_EMPTY;
            bstate[1] <= B_EMPTY;
            wbank     <= 1'b0;
            rbank     <= 1'b0;
            wcnt      <= '0;
            x         <= '0;
            y         <= '0;
            rstate    <= R_IDLE;
            vpipe     <= '0;
            spipe     <= '0;
            epipe     <= '0;
            err_sop   <= 1'b0;
        end else begin
            err_sop <= sop_err_c;

            if (wr_en) begin
                if (wlast_c) begin
                    wcnt          <= '0;
                    wbank         <= ~wbank;
                    bstate[wbank] <= B_FULL;
                end else begin
                    wcnt          <= widx_c + AW'(1);
                    bstate[wbank] <= B_FILLING;
                end
            end

            // Write and read never touch the same bank in one cycle: the
            // write bank is EMPTY/FILLING, the read bank FULL/READING.
            if (bstate[rbank] == B_FULL) begin
                bstate[rbank] <= B_READING;
            end

            if (rd_en) begin
                if (rlast_c) begin
                    x             <= '0;
                    y             <= '0;
                    rbank         <= ~rbank;
                    bstate[rbank] <= B_EMPTY;
                end else begin
                    x <= nx;
                    y <= ny;
                end
            end

            case (rstate)
                R_IDLE: begin
                    if (bstate[rbank] == B_FULL) begin
                        rstate <= R_SCAN;
                    end
                end
                R_SCAN: begin
                    if (rd_en && rlast_c) begin
                        rstate <= (bstate[!rbank] == B_FULL) ? R_SCAN : R_IDLE;
                    end
                end
                default: rstate <= R_IDLE;
            endcase

            vpipe[0] <= rd_en;
            spipe[0] <= rsop_c;
            epipe[0] <= reop_c;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                vpipe[i] <= vpipe[i-1];
                spipe[i] <= spipe[i-1];
                epipe[i] <= epipe[i-1];
            end
        end
    end

endmodule

// File: tb/tb_zigzag_bank_ctrl.sv
// Bench for zigzag_bank_ctrl: directed scenarios plus a randomized phase, all
// checked every cycle against a bank/queue reference model; a few literal
// expectations pin the model itself.
module tb_zigzag_bank_ctrl;

    localparam int unsigned DIM    = 8;
    localparam int unsigned RD_LAT = 1;
    localparam int unsigned LW     = $clog2(DIM);
    localparam int unsigned AW     = 2 * LW;
    localparam int DEPTH = DIM * DIM;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_sop;
    logic          in_ready;
    logic          wr_en;
    logic [AW:0]   wr_addr;
    logic          out_hold;
    logic          rd_en;
    logic [AW:0]   rd_addr;
    logic          out_valid;
    logic          out_sop;
    logic          out_eop;
    logic          out_done;
    logic          err_sop;

    zigzag_bank_ctrl #(.DIM(DIM), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_sop(in_sop), .in_ready(in_ready),
        .wr_en(wr_en), .wr_addr(wr_addr),
        .out_hold(out_hold), .rd_en(rd_en), .rd_addr(rd_addr),
        .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
        .out_done(out_done), .err_sop(err_sop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_bad;
    int cyc_n;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @%0t actual=%0d required=%0d", nm, $time, act, exp);
        end
    endtask

    // Zigzag order built by walking anti-diagonals.
    int zz [DEPTH];
    function automatic void build_zz();
        int k;
        int lo;
        int hi;
        k = 0;
        for (int s = 0; s <= 2 * DIM - 2; s++) begin
            lo = (s > DIM - 1) ? s - (DIM - 1) : 0;
            hi = (s < DIM - 1) ? s : DIM - 1;
            if (s % 2 == 1) begin
                for (int xx = hi; xx >= lo; xx--) begin zz[k] = (s - xx) * DIM + xx; k++; end
            end else begin
                for (int xx = lo; xx <= hi; xx++) begin zz[k] = (s - xx) * DIM + xx; k++; end
            end
        end
    endfunction

    // Reference model: bank states 0 empty, 1 filling, 2 full, 3 reading.
    int m_state [2];
    int old_st  [2];
    int m_wbank, m_wcnt, m_rbank, m_pos;
    int m_err;
    int pv [RD_LAT];
    int ps [RD_LAT];
    int pe [RD_LAT];

    int rd_q [$];
    int rdc_q [$];
    int nvalid, nerr, nsop, neop, ndone;

    function automatic int qget(input int i);
        if (i < rd_q.size()) return rd_q[i];
        return -1;
    endfunction
    function automatic int cget(input int i);
        if (i < rdc_q.size()) return rdc_q[i];
        return -1;
    endfunction

    always @(negedge clk) begin
        int e_ready, e_wren, e_idx, e_rden;
        e_ready = (m_state[m_wbank] <= 1) ? 1 : 0;
        e_wren  = (in_valid && e_ready != 0) ? 1 : 0;
        e_idx   = in_sop ? 0 : m_wcnt;
        e_rden  = (!out_hold && m_state[m_rbank] >= 2) ? 1 : 0;

        chk("in_ready", int'(in_ready), e_ready);
        chk("wr_en", int'(wr_en), e_wren);
        if (e_wren != 0) chk("wr_addr", int'(wr_addr), m_wbank * DEPTH + e_idx);
        chk("rd_en", int'(rd_en), e_rden);
        if (e_rden != 0) chk("rd_addr", int'(rd_addr), m_rbank * DEPTH + zz[m_pos]);
        chk("out_valid", int'(out_valid), pv[RD_LAT-1]);
        chk("out_sop", int'(out_sop), ps[RD_LAT-1]);
        chk("out_eop", int'(out_eop), pe[RD_LAT-1]);
        chk("out_done", int'(out_done), pe[RD_LAT-1]);
        chk("err_sop", int'(err_sop), m_err);

        if (rd_en) begin rd_q.push_back(int'(rd_addr)); rdc_q.push_back(cyc_n); end
        if (out_valid) nvalid++;
        if (out_sop) nsop++;
        if (out_eop) neop++;
        if (out_done) ndone++;
        if (err_sop) nerr++;

        if (!rst_n) begin
            m_state[0] = 0; m_state[1] = 0;
            m_wbank = 0; m_wcnt = 0; m_rbank = 0; m_pos = 0; m_err = 0;
            for (int i = 0; i < RD_LAT; i++) begin pv[i] = 0; ps[i] = 0; pe[i] = 0; end
        end else begin
            for (int i = RD_LAT - 1; i > 0; i--) begin pv[i] = pv[i-1]; ps[i] = ps[i-1]; pe[i] = pe[i-1]; end
            pv[0] = e_rden;
            ps[0] = (e_rden != 0 && m_pos == 0) ? 1 : 0;
            pe[0] = (e_rden != 0 && m_pos == DEPTH - 1) ? 1 : 0;
            m_err = (e_wren != 0 && in_sop && m_wcnt != 0) ? 1 : 0;
            old_st[0] = m_state[0];
            old_st[1] = m_state[1];
            if (e_wren != 0) begin
                if (e_idx == DEPTH - 1) begin
                    m_state[m_wbank] = 2; m_wbank ^= 1; m_wcnt = 0;
                end else begin
                    m_state[m_wbank] = 1; m_wcnt = e_idx + 1;
                end
            end
            if (old_st[m_rbank] == 2) m_state[m_rbank] = 3;
            if (e_rden != 0) begin
                if (m_pos == DEPTH - 1) begin
                    m_state[m_rbank] = 0; m_rbank ^= 1; m_pos = 0;
                end else begin
                    m_pos++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        rd_q.delete(); rdc_q.delete();
        nvalid = 0; nerr = 0; nsop = 0; neop = 0; ndone = 0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0; in_sop = 1'b0; out_hold = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        @(negedge clk);
        chk({tag, "_in_ready"}, int'(in_ready), 1);
        chk({tag, "_wr_en"}, int'(wr_en), 0);
        chk({tag, "_wr_addr"}, int'(wr_addr), 0);
        chk({tag, "_rd_en"}, int'(rd_en), 0);
        chk({tag, "_rd_addr"}, int'(rd_addr), 0);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_out_flags"}, int'({out_sop, out_eop, out_done}), 0);
        chk({tag, "_err_sop"}, int'(err_sop), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic send_words(input int n, input bit sop_first);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_sop   = (sop_first && i == 0);
            tick();
        end
        in_valid = 1'b0;
        in_sop   = 1'b0;
    endtask

    int t1_exp [10] = '{0, 1, 8, 16, 9, 2, 3, 10, 17, 24};

    initial begin
        int acc;
        int stall;
        int w0;
        build_zz();
        n_cmp = 0; n_bad = 0; cyc_n = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_sop = 1'b0; out_hold = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_reset_outputs("reset");

        // T1: single block
        do_reset(); clear_logs();
        w0 = cyc_n;
        send_words(DEPTH, 1'b1);
        repeat (DEPTH + RD_LAT + 4) tick();
        chk("t1_reads", rd_q.size(), DEPTH);
        chk("t1_latency", cget(0) - w0, DEPTH);
        for (int i = 0; i < 10; i++) chk("t1_rd_addr", qget(i), t1_exp[i]);
        chk("t1_last_addr", qget(DEPTH - 1), DEPTH - 1);
        chk("t1_flags", nvalid * 1000 + nsop * 100 + neop * 10 + ndone, DEPTH * 1000 + 111);

        // T2: three blocks back to back
        do_reset(); clear_logs();
        stall = 0;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            in_valid = 1'b1;
            in_sop   = (i % DEPTH == 0);
            @(negedge clk);
            if (!in_ready) stall++;
            if (i >= DEPTH && i < 2 * DEPTH) chk("t2_wr_addr", int'(wr_addr), i);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0; in_sop = 1'b0;
        repeat (DEPTH + 8) tick();
        chk("t2_stalls", stall, 0);
        chk("t2_reads", rd_q.size(), 3 * DEPTH);
        chk("t2_contiguous", cget(3 * DEPTH - 1) - cget(0), 3 * DEPTH - 1);
        chk("t2_bank0", qget(0) / DEPTH, 0);
        chk("t2_bank1", qget(DEPTH) / DEPTH, 1);
        chk("t2_bank2", qget(2 * DEPTH) / DEPTH, 0);

        // T3: backpressure from the start
        do_reset(); clear_logs();
        out_hold = 1'b1;
        acc = 0;
        for (int i = 0; i < 200; i++) begin
            in_valid = 1'b1;
            in_sop   = (acc % DEPTH == 0);
            @(negedge clk);
            if (in_ready) acc++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0; in_sop = 1'b0;
        @(negedge clk);
        chk("t3_accepted", acc, 2 * DEPTH);
        chk("t3_in_ready", int'(in_ready), 0);
        chk("t3_rd_en", int'(rd_en), 0);
        chk("t3_no_reads", rd_q.size(), 0);
        @(posedge clk);
        #1;
        out_hold = 1'b0;
        repeat (2 * DEPTH + 8) tick();
        chk("t3_resume_addr", qget(0), 0);
        chk("t3_reads", rd_q.size(), 2 * DEPTH);
        chk("t3_second_bank", qget(DEPTH), DEPTH);

        // T4: hold for five cycles after the tenth read
        do_reset(); clear_logs();
        send_words(DEPTH, 1'b1);
        repeat (10) tick();
        out_hold = 1'b1;
        @(negedge clk);
        chk("t4_hold_rd_en", int'(rd_en), 0);
        chk("t4_hold_addr", int'(rd_addr), 32);
        chk("t4_issued_word", int'(out_valid), 1);
        @(posedge clk);
        #1;
        repeat (4) tick();
        out_hold = 1'b0;
        repeat (DEPTH + 8) tick();
        chk("t4_reads", rd_q.size(), DEPTH);
        chk("t4_valid_pulses", nvalid, DEPTH);
        chk("t4_resume_addr", qget(10), 32);
        chk("t4_gap", cget(10) - cget(9), 6);

        // T5: in_sop on the twentieth word
        do_reset(); clear_logs();
        send_words(19, 1'b1);
        in_valid = 1'b1; in_sop = 1'b1;
        @(negedge clk);
        chk("t5_sop_wr_en", int'(wr_en), 1);
        chk("t5_sop_index", int'(wr_addr) % DEPTH, 0);
        @(posedge clk);
        #1;
        in_sop = 1'b0;
        send_words(DEPTH - 2, 1'b0);
        in_valid = 1'b1;
        @(negedge clk);
        chk("t5_not_full_yet", rd_q.size(), 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("t5_scan_starts", int'(rd_en), 1);
        @(posedge clk);
        #1;
        repeat (DEPTH + 8) tick();
        chk("t5_err_pulses", nerr, 1);
        chk("t5_reads", rd_q.size(), DEPTH);

        // T6: reset mid-scan with the other bank filling
        do_reset(); clear_logs();
        send_words(DEPTH, 1'b1);
        send_words(20, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        clear_logs();
        chk_reset_outputs("t6");
        repeat (30) tick();
        chk("t6_stale_valid", nvalid, 0);
        chk("t6_stale_reads", rd_q.size(), 0);

        // Randomized traffic, checked cycle by cycle against the model
        do_reset();
        for (int i = 0; i < 6000; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_sop   = ($urandom_range(0, 49) == 0);
            out_hold = (i % 1000 < 300) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 9) == 0);
            rst_n    = ($urandom_range(0, 1499) != 0);
            tick();
        end
        rst_n = 1'b1; in_valid = 1'b0; in_sop = 1'b0; out_hold = 1'b0;
        repeat (2 * DEPTH + 8) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
